// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one requesting FU per cycle and drives the registered CDB.
// Build option CDB_FIXED_PRIO_EN: fixed priority (lowest index wins) instead of round-robin.
module cdb_arbiter #(
    parameter int NUM_FU = 5,
    parameter int FU_W   = 3,
    parameter int RS_W   = 3,
    parameter int DATA_W = 32,
    parameter int PAY_W  = FU_W + RS_W + DATA_W,
    parameter int CDB_W  = 1 + PAY_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_FU-1:0]       req,
    input  logic [NUM_FU*PAY_W-1:0] pay,
    output logic [CDB_W-1:0]        cdb,
    output logic [NUM_FU-1:0]       grant,
    output logic [15:0]             bcast_cnt
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PAY_W-1:0]  pay_arr [NUM_FU];
    logic [NUM_FU-1:0] cand;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_next;
    logic [PTR_W-1:0]  win;
    logic              found;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_pay
        assign pay_arr[g] = pay[g*PAY_W +: PAY_W];
    end

    // The FU currently on the bus may not win again next cycle, so a late drop never duplicates.
    assign cand = req & ~grant;

    always_comb begin
        logic [PTR_W:0] sum;
        logic [PTR_W-1:0] idx;
        sum   = '0;
        idx   = '0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_FU)) begin
                sum = sum - (PTR_W+1)'(NUM_FU);
            end
            idx = sum[PTR_W-1:0];
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

`ifdef CDB_FIXED_PRIO_EN
    assign ptr_next = '0;
`else
    assign ptr_next = (win == PTR_W'(NUM_FU-1)) ? '0 : win + PTR_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb       <= '0;
            grant     <= '0;
            ptr       <= '0;
            bcast_cnt <= '0;
        end else if (flush) begin
            // Squash only; the requester keeps asking and competes again next cycle.
            cdb   <= '0;
            grant <= '0;
        end else if (found) begin
            cdb       <= {1'b1, pay_arr[win]};
            grant     <= NUM_FU'(1) << win;
            ptr       <= ptr_next;
            bcast_cnt <= bcast_cnt + 16'd1;
        end else begin
            cdb   <= '0;
            grant <= '0;
        end
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Single owner and driver of the common data bus (CDB).
- Collects `cdb_request` / `cdb_out` from every functional unit (ALU, MEM, MUL, DIV, JUMP), picks one winner per cycle and drives the registered `cdb` bus that all reservation stations, the register-status table and the FUs sample.
- Closes the request/broadcast loop of the FU units: a unit sees its own FU tag with the ON bit set, treats it as "result taken" and drops its request.

## Interface
Parameters:
- `NUM_FU`, 5 — number of requesting functional units.
- `FU_W`, 3 — FU tag width.
- `RS_W`, 3 — one-hot reservation-station tag width.
- `DATA_W`, 32 — result width.
- `PAY_W` (derived) = `FU_W+RS_W+DATA_W` — width of one FU payload.
- `CDB_W` (derived) = `1+PAY_W`.

Ports:
- `clk` in 1 — single clock; all state updates on posedge.
- `rst` in 1 — synchronous, active-high reset.
- `flush` in 1 — pipeline flush; squashes the broadcast being loaded this cycle.
- `req` in `NUM_FU` — `cdb_request` of FU i on bit i.
- `pay` in `NUM_FU*PAY_W` — `cdb_out` of FU i in slice i, laid out as {fu, rs, data}.
- `cdb` out `CDB_W` — {on, fu, rs, data}; on = MSB.
- `grant` out `NUM_FU` — one-hot source of the current `cdb`; 0 when on=0.
- `bcast_cnt` out 16 — count of broadcasts since reset.

## Operation
- Candidate set each cycle: `cand = req & ~hold`. `hold` = `grant` register, which blocks the FU that owns the bus this cycle from winning again next cycle.
- Round-robin: search `cand` starting at index `ptr`, wrapping modulo `NUM_FU`; the first set bit wins.
- On a win:
  - `cdb` ← {1, pay[w]}
  - `grant` ← onehot(w)
  - `ptr` ← (w+1) mod `NUM_FU`
  - `bcast_cnt` += 1, wrapping 0xFFFF→0.
- No candidate: `cdb` ← all zeros, `grant` ← 0, `ptr` unchanged.
- `flush`=1: `cdb` ← 0, `grant` ← 0, `ptr` and `bcast_cnt` unchanged. The request is not lost; the FU keeps requesting and competes next cycle.
- Payload is copied verbatim. The arbiter never inspects or rewrites the fu/rs fields.
- If `req[i]` is set while the payload's fu field ≠ i, the bus carries the payload as given. This is a system bug and is not detected.

## Timing
- Reset values: `cdb`=0, `grant`=0, `ptr`=0, `bcast_cnt`=0. `rst` takes precedence over `flush`.
- Latency: a request sampled at posedge N appears on `cdb` from N (after clk-to-q) to N+1, i.e. one full cycle.
- Handshake:
  - FUs sample `cdb` at the negedge inside that cycle and must deassert `req` before posedge N+1.
  - The hold mask guarantees that a late drop cannot cause a duplicate broadcast.
- Throughput: one broadcast per cycle. A single FU can win at most every other cycle. With k≥2 requesting FUs the bus is 100% utilised.
- Simultaneous events: when every FU requests, grants rotate 0,1,2,3,4,0,… Worst-case wait for a steady requester is `NUM_FU` cycles.
- `ptr` wrap: winner `NUM_FU-1` → `ptr`=0.
- Reset mid-broadcast: the bus drops to on=0 on the next posedge; pending requests are re-arbitrated from `ptr`=0.

## Configuration
- `CDB_FIXED_PRIO_EN` defined:
  - `ptr` is tied to 0, giving fixed priority with lowest index winning.
  - The hold mask still applies, so FU0 cannot take consecutive cycles.
- Undefined (default): round-robin as above.
- `bcast_cnt` behaviour is identical in both modes.

## Test plan
- Reset → release; `req`=0 for 3 cycles → `cdb`=0, `grant`=0, `bcast_cnt`=0 each cycle.
- Single request: `req`=5'b00100, data 0x0000_002A, rs=3'b010, held 2 cycles → cycle 1: `cdb`={1,fu2,010,0x2A}, `grant`=00100. Cycle 2: on=0 (hold). `bcast_cnt`=1.
- All five request continuously for 10 cycles (round-robin build) → winners alternate in order 0,1,2,3,4,0,…, never the same FU twice in a row; `bcast_cnt`=10.
- Same stimulus with `CDB_FIXED_PRIO_EN` → winners 0,1,0,1,…; FUs 2–4 starve.
- `req`=00011 with `flush`=1 in the cycle FU0 would win → `cdb` on=0. Next cycle FU0 wins, `ptr`=1. `bcast_cnt` does not increment in the flushed cycle.
- `bcast_cnt` preloaded near wrap via 65535 broadcasts, then one more → reads 0. Then `rst`=1 while `cdb` on=1 → next cycle `cdb`=0, `ptr`=0.
